// File: rtl/mips_exec_ctrl.sv
// mips_exec_ctrl: execution sequencer for the pipelined MIPS core.
//
// Gates the pipeline enables, inserts load-use bubbles by flushing the ID/EX
// control buses, and runs the core continuously or one cycle at a time under
// debug-unit commands. It reports the run state, the executed-cycle count and
// the stall count.
//
// Optional feature macro: EXEC_CTRL_STALL_CNT_EN
//   defined   -> o_stall_cnt counts cycles with o_idex_flush=1
//   undefined -> there is no stall counter register, and o_stall_cnt is tied to 0
//
// Ports:
//   i_clk, i_rst        clock and synchronous active-low reset
//   i_cmd_valid, i_cmd  debug command (00 NOP, 01 RUN, 10 STEP, 11 HALT)
//   o_cmd_ready         command accepted when valid & ready at the clock edge
//   i_load_use_hazard   ID instruction depends on a load in EX
//   i_halt_detected     HALT instruction reached WB
//   o_pipe_en           enable for the ID/EX, EX/MEM and MEM/WB latches
//   o_pc_en, o_ifid_en  PC and IF/ID write enables
//   o_idex_flush        zero the ID/EX control buses
//   o_state             00 IDLE, 01 RUN, 10 STEP, 11 DONE
//   o_done              program finished (sticky until reset)
//   o_cycle_cnt         saturating count of cycles with o_pipe_en=1
//   o_stall_cnt         saturating count of cycles with o_idex_flush=1
module mips_exec_ctrl #(
  parameter int unsigned NB_CMD   = 2,
  parameter int unsigned NB_CNT   = 32,
  parameter int unsigned NB_STATE = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cmd_valid,
  input  logic [NB_CMD-1:0]   i_cmd,
  output logic                o_cmd_ready,
  input  logic                i_load_use_hazard,
  input  logic                i_halt_detected,
  output logic                o_pipe_en,
  output logic                o_pc_en,
  output logic                o_ifid_en,
  output logic                o_idex_flush,
  output logic [NB_STATE-1:0] o_state,
  output logic                o_done,
  output logic [NB_CNT-1:0]   o_cycle_cnt,
  output logic [NB_CNT-1:0]   o_stall_cnt
);

  localparam logic [NB_CMD-1:0] CmdRun  = NB_CMD'(1);
  localparam logic [NB_CMD-1:0] CmdStep = NB_CMD'(2);
  localparam logic [NB_CMD-1:0] CmdHalt = NB_CMD'(3);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StStep = 2'b10,
    StDone = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [NB_CNT-1:0] cycle_cnt_q;

  // Ready depends on state only, so a command never loops back through ready.
  assign o_cmd_ready = (state_q == StIdle) || (state_q == StRun);

  always_comb begin
    state_d   = state_q;
    o_pipe_en = 1'b0;
    o_done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_cmd_valid) begin
          if (i_cmd == CmdRun) begin
            state_d = StRun;
          end else if (i_cmd == CmdStep) begin
            state_d = StStep;
          end
        end
      end
      StRun: begin
        o_pipe_en = 1'b1;
        // A finished program beats a simultaneous pause request.
        if (i_halt_detected) begin
          state_d = StDone;
        end else if (i_cmd_valid && (i_cmd == CmdHalt)) begin
          state_d = StIdle;
        end
      end
      StStep: begin
        o_pipe_en = 1'b1;
        state_d   = i_halt_detected ? StDone : StIdle;
      end
      StDone: begin
        o_done = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // A step that lands on a hazard cycle is spent as the bubble.
  assign o_pc_en      = o_pipe_en & ~i_load_use_hazard;
  assign o_ifid_en    = o_pipe_en & ~i_load_use_hazard;
  assign o_idex_flush = o_pipe_en & i_load_use_hazard;
  assign o_state      = NB_STATE'(state_q);
  assign o_cycle_cnt  = cycle_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= StIdle;
      cycle_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (o_pipe_en && (cycle_cnt_q != '1)) begin
        cycle_cnt_q <= cycle_cnt_q + NB_CNT'(1);
      end
    end
  end

`ifdef EXEC_CTRL_STALL_CNT_EN
  logic [NB_CNT-1:0] stall_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      stall_cnt_q <= '0;
    end else if (o_idex_flush && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + NB_CNT'(1);
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`else
  assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Testbench for mips_exec_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model. A second instance with
// 4-bit counters shares the stimulus to exercise counter saturation.
module tb_mips_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic        haz;
  logic        halt;

  logic        cmd_ready, pipe_en, pc_en, ifid_en, idex_flush, done;
  logic [1:0]  state;
  logic [31:0] cycle_cnt, stall_cnt;

  logic        s_cmd_ready, s_pipe_en, s_pc_en, s_ifid_en, s_idex_flush, s_done;
  logic [1:0]  s_state;
  logic [3:0]  s_cycle_cnt, s_stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Model: 0 idle, 1 run, 2 step, 3 done; counters kept unsaturated.
  int     m_st;
  longint m_cyc;
  longint m_stall;
  bit     m_known = 1'b0;

  always #5 clk = ~clk;

  mips_exec_ctrl #(.NB_CMD(2), .NB_CNT(32), .NB_STATE(2)) u_dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_cmd_valid      (cmd_valid),
    .i_cmd            (cmd),
    .o_cmd_ready      (cmd_ready),
    .i_load_use_hazard(haz),
    .i_halt_detected  (halt),
    .o_pipe_en        (pipe_en),
    .o_pc_en          (pc_en),
    .o_ifid_en        (ifid_en),
    .o_idex_flush     (idex_flush),
    .o_state          (state),
    .o_done           (done),
    .o_cycle_cnt      (cycle_cnt),
    .o_stall_cnt      (stall_cnt)
  );

  mips_exec_ctrl #(.NB_CMD(2), .NB_CNT(4), .NB_STATE(2)) u_dut_small (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_cmd_valid      (cmd_valid),
    .i_cmd            (cmd),
    .o_cmd_ready      (s_cmd_ready),
    .i_load_use_hazard(haz),
    .i_halt_detected  (halt),
    .o_pipe_en        (s_pipe_en),
    .o_pc_en          (s_pc_en),
    .o_ifid_en        (s_ifid_en),
    .o_idex_flush     (s_idex_flush),
    .o_state          (s_state),
    .o_done           (s_done),
    .o_cycle_cnt      (s_cycle_cnt),
    .o_stall_cnt      (s_stall_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint max_v;
    max_v = (longint'(1) << w) - 1;
    return (v > max_v) ? max_v : v;
  endfunction

  function automatic longint exp_stall(input int w);
`ifdef EXEC_CTRL_STALL_CNT_EN
    return sat(m_stall, w);
`else
    return 0;
`endif
  endfunction

  // One clock cycle: drive inputs, compare outputs mid-cycle, advance model at the edge.
  task automatic cycle(input logic r, input logic v, input logic [1:0] c,
                       input logic hz, input logic hd);
    bit running;
    rst       = r;
    cmd_valid = v;
    cmd       = c;
    haz       = hz;
    halt      = hd;
    @(negedge clk);
    if (m_known) begin
      running = (m_st == 1) || (m_st == 2);
      check_eq("pipe_en",     pipe_en,     running);
      check_eq("pc_en",       pc_en,       running && !hz);
      check_eq("ifid_en",     ifid_en,     running && !hz);
      check_eq("idex_flush",  idex_flush,  running && hz);
      check_eq("cmd_ready",   cmd_ready,   (m_st == 0) || (m_st == 1));
      check_eq("done",        done,        m_st == 3);
      check_eq("state",       state,       m_st);
      check_eq("cycle_cnt",   cycle_cnt,   sat(m_cyc, 32));
      check_eq("stall_cnt",   stall_cnt,   exp_stall(32));
      check_eq("s_state",     s_state,     m_st);
      check_eq("s_cycle_cnt", s_cycle_cnt, sat(m_cyc, 4));
      check_eq("s_stall_cnt", s_stall_cnt, exp_stall(4));
    end
    @(posedge clk);
    if (!r) begin
      m_st    = 0;
      m_cyc   = 0;
      m_stall = 0;
      m_known = 1'b1;
    end else if (m_known) begin
      running = (m_st == 1) || (m_st == 2);
      if (running) m_cyc++;
      if (running && hz) m_stall++;
      case (m_st)
        0: if (v && c == 2'b01) m_st = 1;
           else if (v && c == 2'b10) m_st = 2;
        1: if (hd) m_st = 3;
           else if (v && c == 2'b11) m_st = 0;
        2: m_st = hd ? 3 : 0;
        default: m_st = 3;
      endcase
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd = 2'b00; haz = 1'b0; halt = 1'b0;

    // Reset then idle.
    do_reset();
    idle(10);
    check_eq("idle_state", state, 2'b00);
    check_eq("idle_cnt", cycle_cnt, 0);

    // Run 20 cycles then a halt pulse: 21 advances, then DONE.
    cycle(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    idle(20);
    cycle(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    check_eq("run_halt_cnt", cycle_cnt, 21);
    check_eq("run_halt_done", done, 1'b1);
    check_eq("run_halt_state", state, 2'b11);
    check_eq("sat_cnt", s_cycle_cnt, 4'hf);
    cycle(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    idle(3);
    check_eq("done_sticky_ready", cmd_ready, 1'b0);
    check_eq("done_sticky_pipe", pipe_en, 1'b0);

    // Three single steps.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
      idle(3);
      check_eq("step_idle", state, 2'b00);
    end
    check_eq("step_cnt", cycle_cnt, 3);

    // Step on a hazard cycle is consumed as the bubble.
    cycle(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    idle(2);

    // Load-use stall while running.
    do_reset();
    cycle(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    idle(2);
    cycle(1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
`ifdef EXEC_CTRL_STALL_CNT_EN
    check_eq("stall_one", stall_cnt, 1);
`else
    check_eq("stall_zero", stall_cnt, 0);
`endif

    // Pause: HALT command returns to IDLE and counters freeze.
    cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
    idle(4);
    check_eq("pause_state", state, 2'b00);
    check_eq("pause_cnt", cycle_cnt, 4);

    // HALT command and halt detection together: DONE wins.
    cycle(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    idle(2);
    cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b1);
    check_eq("conflict_state", state, 2'b11);

    // Reset mid-run freezes the pipeline and clears counters.
    do_reset();
    cycle(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    idle(3);
    cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    check_eq("rst_mid_pipe", pipe_en, 1'b0);
    check_eq("rst_mid_cnt", cycle_cnt, 0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(59) != 0), ($urandom_range(2) != 0), 2'($urandom_range(3)),
            ($urandom_range(3) == 0), ($urandom_range(39) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_exec_ctrl.md
# mips_exec_ctrl

Execution sequencer for the pipelined MIPS core. It gates the pipeline enables (PC, IF/ID and the downstream latches), inserts load-use bubbles by flushing the ID/EX control buses, and runs the core in continuous or single-step mode under commands from the debug unit. It sits between the debug unit and the pipeline-register enable and flush inputs, and reports run state, executed-cycle count and stall count back to the debug unit.

## Interface
- NB_CMD, 2, command width
- NB_CNT, 32, width of cycle and stall counters
- NB_STATE, 2, width of state report
- i_clk  in  1  rising-edge clock
- i_rst  in  1  reset; synchronous, active-low
- i_cmd_valid  in  1  command present
- i_cmd  in  NB_CMD  2'b00 NOP, 2'b01 RUN, 2'b10 STEP, 2'b11 HALT
- o_cmd_ready  out  1  command accepted when i_cmd_valid & o_cmd_ready at clock edge
- i_load_use_hazard  in  1  hazard unit: ID instruction depends on a load in EX
- i_halt_detected  in  1  HALT instruction reached WB
- o_pipe_en  out  1  enable for ID/EX, EX/MEM, MEM/WB latches
- o_pc_en  out  1  PC write enable
- o_ifid_en  out  1  IF/ID write enable
- o_idex_flush  out  1  force ID/EX control buses (WB, MEM, EX) to zero
- o_state  out  NB_STATE  00 IDLE, 01 RUN, 10 STEP, 11 DONE
- o_done  out  1  program finished
- o_cycle_cnt  out  NB_CNT  cycles with o_pipe_en=1
- o_stall_cnt  out  NB_CNT  cycles with o_idex_flush=1

## Operation
- FSM states: IDLE, RUN, STEP, DONE. State is registered; all other outputs are combinational from state, hazard and counters.
- IDLE: o_cmd_ready=1. RUN goes to RUN; STEP goes to STEP; NOP and HALT are accepted with no effect.
- RUN: o_cmd_ready=1. i_halt_detected goes to DONE. An accepted HALT goes to IDLE (pause). RUN, STEP and NOP are accepted and ignored.
- STEP: o_cmd_ready=0. The FSM stays exactly one cycle, then goes to IDLE, or to DONE if i_halt_detected is high in that cycle.
- DONE: o_cmd_ready=0 and o_done=1. The state is sticky until reset.
- Simultaneous i_halt_detected and an accepted HALT in RUN: DONE wins.
- o_pipe_en=1 in RUN and STEP only.
- o_pc_en = o_ifid_en = o_pipe_en & ~i_load_use_hazard.
- o_idex_flush = o_pipe_en & i_load_use_hazard. While paused, no flush occurs and all latches hold.
- o_cycle_cnt increments when o_pipe_en=1. o_stall_cnt increments when o_idex_flush=1. Both saturate at all-ones, with no wrap. Both clear only on reset.
- A STEP issued during a hazard cycle consumes that step as the bubble: PC holds and ID/EX is flushed.

## Timing
- Reset (i_rst=0 at an edge): state IDLE, both counters 0. This gives o_pipe_en=0, o_pc_en=0, o_ifid_en=0, o_idex_flush=0, o_done=0, o_state=00, o_cmd_ready=1.
- Reset mid-RUN or mid-STEP: the pipeline freezes in the cycle after the edge, and the counters read 0.
- Command latency: a command accepted at edge N changes the state at edge N. o_pipe_en is high from edge N to N+1, so the first pipeline advance happens at edge N+1.
- STEP: exactly one cycle of o_pipe_en=1, so exactly one edge advances the pipeline.
- i_halt_detected is sampled only in RUN or STEP. o_done rises the cycle after the sampling edge, and o_pipe_en falls together with it.
- Hazard response has zero latency: the enables and flush follow i_load_use_hazard in the same cycle.

## Configuration
- EXEC_CTRL_STALL_CNT_EN defined: o_stall_cnt is implemented as described.
- EXEC_CTRL_STALL_CNT_EN undefined: no stall counter register exists, and o_stall_cnt is tied to 0. All other behaviour is unchanged.

## Test plan
- Reset then idle: i_rst=0 for 2 cycles, then 1 with no commands. Required: o_state=00, o_pipe_en=0, and both counters 0 for 10 cycles.
- Run and halt: RUN accepted, 20 cycles, then pulse i_halt_detected. Required: o_cycle_cnt=21, o_done=1, o_state=11, o_pipe_en=0, and o_cmd_ready=0 stays low thereafter.
- Single step: three STEP commands spaced 4 cycles apart. Required: o_pipe_en is high for exactly 3 cycles total, o_cycle_cnt=3, and the FSM is back in IDLE after each step.
- Load-use stall: RUN, then i_load_use_hazard=1 for 1 cycle. In that cycle required: o_pc_en=0, o_ifid_en=0, o_idex_flush=1, o_pipe_en=1. After it, o_stall_cnt=1 (0 without EXEC_CTRL_STALL_CNT_EN).
- Pause and conflict: HALT command alone in RUN goes to IDLE and the counters freeze. Separately, RUN, then HALT command and i_halt_detected at the same edge: required state DONE.
- Saturation: NB_CNT=4, RUN for 20 cycles. Required: o_cycle_cnt=4'hF, with no wrap.
